param_priority_arbiter: RTL and testbench
=========================================

Name: param_priority_arbiter

Overview:
- Parametrised, registered successor to the team's 8-to-3 fixed-priority encoder.
- Takes N request lines and issues one registered grant, given as both an index and a one-hot vector.
- The grant locks to its holder while the holder keeps requesting.
- Selectable at run time between fixed priority (highest index wins) and round-robin.
- An optional hold limit pre-empts a holder that has kept the grant too long.
- Sits in front of shared resources (bus, memory port, output mux) in the datapath.

Parameters:
- N, 8, number of requesters (N >= 2).
- W, $clog2(N), grant index width (derived; do not override).
- MAX_HOLD, 0, maximum consecutive grant cycles before pre-emption; 0 disables pre-emption.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  N  request vector; bit i high means requester i wants the resource.
- mode_rr  input  1  0 selects fixed priority, 1 selects round-robin; sampled only at arbitration points.
- gnt_valid  output  1  a grant is active.
- gnt_idx  output  W  index of the current holder; 0 when gnt_valid is 0.
- gnt_onehot  output  N  one-hot form of gnt_idx; all zero when gnt_valid is 0.
- preempt  output  1  one-cycle pulse in the cycle after a forced hand-over.

Behaviour:
- Reset (rst high at an edge):
  - gnt_valid=0, gnt_idx=0, gnt_onehot=0, preempt=0.
  - State goes to IDLE, last_idx=0, hold_cnt=0.
  - Reset overrides any grant in progress: outputs are zero after that edge.
- All outputs are registered. Latency from a request being raised to the grant appearing is 1 clock.
- States: IDLE and GRANT.
- IDLE:
  - If req is all zero, stay in IDLE.
  - Otherwise arbitrate, load gnt_idx, gnt_onehot and last_idx, clear hold_cnt, go to GRANT.
- GRANT, holder still requesting (req[gnt_idx]=1):
  - Hold the grant and increment hold_cnt.
  - Pre-emption applies only when MAX_HOLD>0, hold_cnt==MAX_HOLD-1 and some other bit of req is high.
  - On pre-emption: arbitrate with the holder masked out, grant the winner, clear hold_cnt, pulse preempt on the next cycle.
  - If the limit is reached but no other request is pending: keep the holder, clear hold_cnt, no pulse.
- GRANT, holder has dropped its request (req[gnt_idx]=0):
  - Arbitrate over req in the same cycle.
  - If there is a winner: grant it on the next edge, with no idle bubble, and stay in GRANT.
  - If there is no winner: go to IDLE with gnt_valid=0.
- Fixed-priority arbitration (mode_rr=0): the highest set index wins, matching the existing encoder ordering.
- Round-robin arbitration (mode_rr=1):
  - Search order is last_idx-1, last_idx-2, ..., 0, N-1, ..., last_idx, wrapping modulo N.
  - Straight after reset (last_idx=0) this order equals fixed priority.
- Masked arbitration (pre-emption) uses the same search order with the holder's bit forced to 0.
- mode_rr changes only take effect at the next arbitration point. A grant in progress is never revoked by a mode change.
- Invariants:
  - gnt_onehot is always zero or exactly one-hot.
  - gnt_onehot[gnt_idx] equals gnt_valid.
  - A grant is issued only to an index whose req bit was high at the arbitration edge.
- Width rules:
  - hold_cnt width is $clog2(MAX_HOLD+1), minimum 1.
  - The wrap of the round-robin search order uses modulo-N arithmetic, so non-power-of-2 N is legal.

Decomposition:
- Shared package arb_pkg:
  - state enum (IDLE, GRANT).
  - function clog2_min1.
  - localparams for mode encodings (MODE_FIXED=0, MODE_RR=1).
- One combinational sub-module, prio_pick, parametrised by N:
  - Inputs: req, mask, start_idx, rr_en.
  - Outputs: found and win_idx.
  - Instantiated once. The top level supplies mask (all ones, or the holder cleared) and start_idx (last_idx).

Test Plan (N=8, MAX_HOLD=4):
- Reset, then req=8'b1010_0100 with mode_rr=0 -> 1 cycle later gnt_valid=1, gnt_idx=7, gnt_onehot=8'h80.
- Fixed mode, holder 7 drops its request while req=8'b0010_0100 -> next cycle gnt_idx=5 with no gnt_valid gap. Then req=0 -> next cycle gnt_valid=0, gnt_idx=0.
- mode_rr=1, all eight requesters pulse for one cycle after each grant -> grant sequence 7,6,5,4,3,2,1,0,7.
- Pre-emption: req[3] held high continuously and req[1] high -> idx 3 granted for 4 cycles, then gnt_idx=1 with preempt high for exactly 1 cycle. Same test with only req[3] high -> idx 3 holds indefinitely and preempt stays 0.
- rst asserted for one edge while idx 5 is granted -> all outputs zero after that edge. With req still high, the grant is re-issued (fixed: idx 5) 1 cycle after rst deasserts.
- mode_rr toggled 0->1 mid-grant -> the holder is unchanged until it releases. The next winner follows the round-robin order from last_idx.

Source files
------------

// File: rtl/param_priority_arbiter_pkg.sv
// arb_pkg: shared types and constants for param_priority_arbiter
//   state_t     arbiter FSM states (IDLE, GRANT)
//   MODE_*      encodings of the mode_rr input
//   clog2_min1  ceil(log2(v)) with a floor of 1 bit
package arb_pkg;
    typedef enum logic {IDLE, GRANT} state_t;
    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR = 1'b1;
    function automatic int clog2_min1(input int v);
        return (v <= 1) ? 1 : $clog2(v);
    endfunction
endpackage

// File: rtl/param_priority_arbiter_prio_pick.sv
// prio_pick: combinational priority search over masked requests
//   req, mask   candidates are req & mask
//   start_idx   round-robin origin; search runs start_idx-1 downward, wrapping mod N
//   rr_en       0: origin forced to 0, i.e. highest index wins
//   found       some candidate exists
//   win_idx     index of the first candidate in search order
module prio_pick #(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [N-1:0] mask,
    input  logic [W-1:0] start_idx,
    input  logic         rr_en,
    output logic         found,
    output logic [W-1:0] win_idx
);
    logic [N-1:0] v;
    int s;
    assign v = req & mask;
    assign s = rr_en ? int'(start_idx) : 0;
    // Walk from the lowest priority up so the highest-priority hit is written last.
    always_comb begin
        found = 1'b0;
        win_idx = '0;
        for (int k = N; k >= 1; k--) begin
            if (v[(s + N - k) % N]) begin
                found = 1'b1;
                win_idx = W'((s + N - k) % N);
            end
        end
    end
endmodule

// File: rtl/param_priority_arbiter.sv
// param_priority_arbiter: registered N-way arbiter, fixed or round-robin, with optional hold limit
//   clk, rst     clock, synchronous active-high reset
//   req          request vector
//   mode_rr      0 fixed priority (highest index), 1 round-robin; used at arbitration points only
//   gnt_valid    grant active
//   gnt_idx      holder index (0 when idle)
//   gnt_onehot   one-hot holder (0 when idle)
//   preempt      one-cycle pulse after a forced hand-over
module param_priority_arbiter
    import arb_pkg::*;
#(
    parameter int N = 8,
    parameter int W = $clog2(N),
    parameter int MAX_HOLD = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         mode_rr,
    output logic         gnt_valid,
    output logic [W-1:0] gnt_idx,
    output logic [N-1:0] gnt_onehot,
    output logic         preempt
);
    localparam int HW = clog2_min1(MAX_HOLD + 1);
    state_t state;
    logic [W-1:0] last_idx;
    logic [HW-1:0] hold_cnt;
    logic holding, limit, do_pre, found;
    logic [N-1:0] mask;
    logic [W-1:0] win_idx;
    assign holding = (state == GRANT) && req[gnt_idx];
    assign limit = (MAX_HOLD > 0) && (hold_cnt == HW'(MAX_HOLD - 1));
    assign do_pre = holding && limit && |(req & ~gnt_onehot);
    // The holder is masked only when being pre-empted; a released holder has req=0 anyway.
    assign mask = do_pre ? ~gnt_onehot : '1;
    prio_pick #(.N(N), .W(W)) u_pick (
        .req(req),
        .mask(mask),
        .start_idx(last_idx),
        .rr_en(mode_rr == MODE_RR),
        .found(found),
        .win_idx(win_idx)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            gnt_valid <= 1'b0;
            gnt_idx <= '0;
            gnt_onehot <= '0;
            preempt <= 1'b0;
            last_idx <= '0;
            hold_cnt <= '0;
        end else begin
            preempt <= 1'b0;
            if (holding && !do_pre) begin
                hold_cnt <= limit ? '0 : hold_cnt + 1'b1;
            end else if (found) begin
                state <= GRANT;
                gnt_valid <= 1'b1;
                gnt_idx <= win_idx;
                gnt_onehot <= {{(N-1){1'b0}}, 1'b1} << win_idx;
                last_idx <= win_idx;
                hold_cnt <= '0;
                preempt <= do_pre;
            end else begin
                state <= IDLE;
                gnt_valid <= 1'b0;
                gnt_idx <= '0;
                gnt_onehot <= '0;
                hold_cnt <= '0;
            end
        end
    end
endmodule

// File: tb/tb_param_priority_arbiter.sv
// tb_param_priority_arbiter: directed vector bench for param_priority_arbiter (N=8, MAX_HOLD=4)
module tb_param_priority_arbiter;
    logic clk = 1'b0;
    logic rst;
    logic [7:0] req;
    logic mode_rr;
    logic gnt_valid;
    logic [2:0] gnt_idx;
    logic [7:0] gnt_onehot;
    logic preempt;
    int errors = 0;
    int checks = 0;

    typedef struct {
        string name;
        logic rst;
        logic [7:0] req;
        logic mode_rr;
        logic valid;
        logic [2:0] idx;
        logic [7:0] onehot;
        logic pre;
    } vec_t;

    param_priority_arbiter #(.N(8), .MAX_HOLD(4)) dut (
        .clk(clk),
        .rst(rst),
        .req(req),
        .mode_rr(mode_rr),
        .gnt_valid(gnt_valid),
        .gnt_idx(gnt_idx),
        .gnt_onehot(gnt_onehot),
        .preempt(preempt)
    );

    always #5 clk = ~clk;

    task automatic step(input logic r, input logic [7:0] q, input logic m);
        rst = r;
        req = q;
        mode_rr = m;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic v, input logic [2:0] i, input logic [7:0] o, input logic p);
        checks++;
        if ({gnt_valid, gnt_idx, gnt_onehot, preempt} !== {v, i, o, p}) begin
            errors++;
            $display("FAIL %s: got valid=%b idx=%0d onehot=%h preempt=%b, expected valid=%b idx=%0d onehot=%h preempt=%b",
                     name, gnt_valid, gnt_idx, gnt_onehot, preempt, v, i, o, p);
        end
    endtask

    vec_t vecs[11];

    initial begin
        vecs[0]  = '{"reset",        1'b1, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0};
        vecs[1]  = '{"fixed_first",  1'b0, 8'hA4, 1'b0, 1'b1, 3'd7, 8'h80, 1'b0};
        vecs[2]  = '{"fixed_handoff",1'b0, 8'h24, 1'b0, 1'b1, 3'd5, 8'h20, 1'b0};
        vecs[3]  = '{"fixed_idle",   1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0};
        vecs[4]  = '{"grant5",       1'b0, 8'h20, 1'b0, 1'b1, 3'd5, 8'h20, 1'b0};
        vecs[5]  = '{"rst_mid",      1'b1, 8'h20, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0};
        vecs[6]  = '{"regrant5",     1'b0, 8'h20, 1'b0, 1'b1, 3'd5, 8'h20, 1'b0};
        vecs[7]  = '{"mode_hold1",   1'b0, 8'h61, 1'b1, 1'b1, 3'd5, 8'h20, 1'b0};
        vecs[8]  = '{"mode_hold2",   1'b0, 8'h61, 1'b1, 1'b1, 3'd5, 8'h20, 1'b0};
        vecs[9]  = '{"mode_rr_next", 1'b0, 8'h41, 1'b1, 1'b1, 3'd0, 8'h01, 1'b0};
        vecs[10] = '{"reset2",       1'b1, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0};
        for (int n = 0; n < 11; n++) begin
            step(vecs[n].rst, vecs[n].req, vecs[n].mode_rr);
            chk(vecs[n].name, vecs[n].valid, vecs[n].idx, vecs[n].onehot, vecs[n].pre);
        end

        // Round-robin: every requester pulses for one cycle, then all drop.
        for (int n = 0; n < 9; n++) begin
            logic [2:0] e;
            e = 3'(7 - n);
            step(1'b0, 8'hFF, 1'b1);
            chk($sformatf("rr_grant%0d", n), 1'b1, e, 8'h01 << e, 1'b0);
            step(1'b0, 8'h00, 1'b1);
            chk($sformatf("rr_idle%0d", n), 1'b0, 3'd0, 8'h00, 1'b0);
        end

        // Pre-emption: 3 and 1 both requesting, fixed priority.
        step(1'b1, 8'h00, 1'b0);
        for (int n = 0; n < 4; n++) begin
            step(1'b0, 8'h0A, 1'b0);
            chk($sformatf("pre_hold%0d", n), 1'b1, 3'd3, 8'h08, 1'b0);
        end
        step(1'b0, 8'h0A, 1'b0);
        chk("pre_switch", 1'b1, 3'd1, 8'h02, 1'b1);
        step(1'b0, 8'h0A, 1'b0);
        chk("pre_pulse_end", 1'b1, 3'd1, 8'h02, 1'b0);

        // Only the holder requesting: never pre-empted.
        step(1'b1, 8'h00, 1'b0);
        for (int n = 0; n < 12; n++) begin
            step(1'b0, 8'h08, 1'b0);
            chk($sformatf("solo%0d", n), 1'b1, 3'd3, 8'h08, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
